// File: rtl/node_ctrl.sv
// node_ctrl: drives one 10-neuron node slice through a layer pass.
// It streams N_IN input elements through the node one step at a time,
// then sweeps the node output mux and writes the 10 results to memory.
module node_ctrl #(
    parameter int N_IN     = 784,  // input elements per pass (1..1023)
    parameter int MEM_LAT  = 1,    // rd_en to valid data latency (1..7)
    parameter int OUT_BASE = 0,    // base write address of the results
    parameter int TIMEOUT  = 255   // node wait limit in cycles (1..255)
) (
    input  logic        clock_ctrl_in,
    input  logic        reset_n_ctrl_in,
    input  logic        start_top2c,
    output logic        busy_c2top,
    output logic        layer_done_c2top,
    output logic        error_c2top,
    output logic        rd_en_c2mem,
    output logic [9:0]  rd_addr_c2mem,
    output logic        head_c2node,
    input  logic        done_flag_node2c,
    output logic [3:0]  data_sel_c2node,
    input  logic [31:0] data_node2mem,
    output logic        wr_en_c2mem,
    output logic [9:0]  wr_addr_c2mem,
    output logic [31:0] wr_data_c2mem
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_MEM, FIRE, WAIT_NODE, DRAIN, FINISH
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(N_IN - 1);
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [9:0] BASE     = 10'(OUT_BASE);
    localparam logic [3:0] N_OUT    = 4'd10;
    localparam logic [3:0] SEL_OFF  = 4'hF;

    state_t      state_q, state_d;
    logic [9:0]  idx_q;        // current input element
    logic [3:0]  k_q;          // drain select index (10 = final write cycle)
    logic [2:0]  lat_q;        // memory latency countdown
    logic [7:0]  tmo_q;        // cycles spent in WAIT_NODE for this step
    logic        err_q;
    logic        vld_p1;       // drain select issued last cycle
    logic [9:0]  wr_addr_p1;   // address matching the select issued last cycle

    // The first WAIT_NODE cycle is masked: neurons are still clearing done.
    logic node_done;
    assign node_done = (tmo_q != 8'd0) && done_flag_node2c;

    // State register
    always_ff @(posedge clock_ctrl_in or negedge reset_n_ctrl_in) begin
        if (!reset_n_ctrl_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        state_d          = state_q;
        busy_c2top       = (state_q != IDLE);
        layer_done_c2top = 1'b0;
        rd_en_c2mem      = 1'b0;
        rd_addr_c2mem    = 10'd0;
        head_c2node      = 1'b0;
        data_sel_c2node  = SEL_OFF;
        case (state_q)
            IDLE: begin
                if (start_top2c) state_d = FETCH;
            end
            FETCH: begin
                rd_en_c2mem   = 1'b1;
                rd_addr_c2mem = idx_q;
                state_d       = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (lat_q == 3'd0) state_d = FIRE;
            end
            FIRE: begin
                head_c2node = 1'b1;
                state_d     = WAIT_NODE;
            end
            WAIT_NODE: begin
                if (node_done) begin
                    state_d = (idx_q == LAST_IDX) ? DRAIN : FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FINISH;
                end
            end
            DRAIN: begin
                if (k_q < N_OUT) begin
                    data_sel_c2node = k_q;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                layer_done_c2top = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Element index, latency/timeout counters, drain index and error flag
    always_ff @(posedge clock_ctrl_in or negedge reset_n_ctrl_in) begin
        if (!reset_n_ctrl_in) begin
            idx_q <= 10'd0;
            k_q   <= 4'd0;
            lat_q <= 3'd0;
            tmo_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_top2c) begin
                        idx_q <= 10'd0;
                        err_q <= 1'b0;
                    end
                end
                FETCH: begin
                    lat_q <= LAT_INIT;
                end
                WAIT_MEM: begin
                    if (lat_q != 3'd0) lat_q <= lat_q - 3'd1;
                end
                FIRE: begin
                    tmo_q <= 8'd0;
                end
                WAIT_NODE: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (node_done) begin
                        if (idx_q == LAST_IDX) begin
                            k_q <= 4'd0;
                        end else begin
                            idx_q <= idx_q + 10'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (k_q < N_OUT) k_q <= k_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // ---- stage p1: write port lags the select by one cycle to meet registered node output
    always_ff @(posedge clock_ctrl_in or negedge reset_n_ctrl_in) begin
        if (!reset_n_ctrl_in) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= 10'd0;
        end else begin
            vld_p1     <= (state_q == DRAIN) && (k_q < N_OUT);
            wr_addr_p1 <= ((state_q == DRAIN) && (k_q < N_OUT)) ? BASE + {6'd0, k_q} : 10'd0;
        end
    end

    assign wr_en_c2mem   = vld_p1;
    assign wr_addr_c2mem = wr_addr_p1;
    assign wr_data_c2mem = vld_p1 ? data_node2mem : 32'd0;
    assign error_c2top   = err_q;

endmodule

// File: tb/tb_node_ctrl.sv
// tb_node_ctrl: scoreboard bench for node_ctrl with a behavioural node model.
// Instance A: N_IN=3, MEM_LAT=1, OUT_BASE=0, TIMEOUT=4.
// Instance B: N_IN=3, MEM_LAT=3, OUT_BASE=1020, TIMEOUT=4.
module tb_node_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_b, start_a, start_b;
    logic        done_flag = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] node_data = 32'd0;

    logic        busy_a, ldone_a, err_a, rd_en_a, head_a, wr_en_a;
    logic [9:0]  rd_addr_a, wr_addr_a;
    logic [3:0]  sel_a;
    logic [31:0] wr_data_a;
    logic        busy_b, ldone_b, err_b, rd_en_b, head_b, wr_en_b;
    logic [9:0]  rd_addr_b, wr_addr_b;
    logic [3:0]  sel_b;
    logic [31:0] wr_data_b;

    node_ctrl #(.N_IN(3), .MEM_LAT(1), .OUT_BASE(0), .TIMEOUT(4)) dut_a (
        .clock_ctrl_in(clk), .reset_n_ctrl_in(rst_n_a), .start_top2c(start_a),
        .busy_c2top(busy_a), .layer_done_c2top(ldone_a), .error_c2top(err_a),
        .rd_en_c2mem(rd_en_a), .rd_addr_c2mem(rd_addr_a), .head_c2node(head_a),
        .done_flag_node2c(done_flag), .data_sel_c2node(sel_a),
        .data_node2mem(node_data), .wr_en_c2mem(wr_en_a),
        .wr_addr_c2mem(wr_addr_a), .wr_data_c2mem(wr_data_a)
    );

    node_ctrl #(.N_IN(3), .MEM_LAT(3), .OUT_BASE(1020), .TIMEOUT(4)) dut_b (
        .clock_ctrl_in(clk), .reset_n_ctrl_in(rst_n_b), .start_top2c(start_b),
        .busy_c2top(busy_b), .layer_done_c2top(ldone_b), .error_c2top(err_b),
        .rd_en_c2mem(rd_en_b), .rd_addr_c2mem(rd_addr_b), .head_c2node(head_b),
        .done_flag_node2c(done_flag), .data_sel_c2node(sel_b),
        .data_node2mem(node_data), .wr_en_c2mem(wr_en_b),
        .wr_addr_c2mem(wr_addr_b), .wr_data_c2mem(wr_data_b)
    );

    // active instance selection
    bit act = 1'b0;
    logic        m_busy, m_ldone, m_err, m_rd_en, m_head, m_wr_en;
    logic [9:0]  m_rd_addr, m_wr_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_wr_data;
    assign m_busy    = act ? busy_b    : busy_a;
    assign m_ldone   = act ? ldone_b   : ldone_a;
    assign m_err     = act ? err_b     : err_a;
    assign m_rd_en   = act ? rd_en_b   : rd_en_a;
    assign m_head    = act ? head_b    : head_a;
    assign m_wr_en   = act ? wr_en_b   : wr_en_a;
    assign m_rd_addr = act ? rd_addr_b : rd_addr_a;
    assign m_wr_addr = act ? wr_addr_b : wr_addr_a;
    assign m_sel     = act ? sel_b     : sel_a;
    assign m_wr_data = act ? wr_data_b : wr_data_a;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] node_val(input logic [3:0] s);
        return 32'h5A00_0011 + 32'(s) * 32'h0001_0203;
    endfunction

    // node model: 0 = done two cycles after head, 1 = done stuck high, 2 = never done
    int dmode = 0;
    always @(posedge clk) begin
        node_data <= (m_sel == 4'hF) ? 32'd0 : node_val(m_sel);
        case (dmode)
            0: begin
                if (m_head) begin
                    done_flag <= 1'b0;
                    pend      <= 1'b1;
                end else if (pend) begin
                    done_flag <= 1'b1;
                    pend      <= 1'b0;
                end
            end
            1: done_flag <= 1'b1;
            default: done_flag <= 1'b0;
        endcase
    end

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    // scoreboard
    logic [9:0]  rq[$];
    logic [9:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int nheads, nwr, ndone, done_cyc, last_rd, last_head;
    int exp_rd_head, exp_head_gap;

    initial begin
        nheads = 0; nwr = 0; ndone = 0; done_cyc = 0; last_rd = 0; last_head = -1;
        forever begin
            @(negedge clk);
            if (m_rd_en) begin
                last_rd = cyc;
                if (rq.size() == 0) check("rd_unexpected", 32'(m_rd_addr), 32'hFFFF_FFFF);
                else check("rd_addr", 32'(m_rd_addr), 32'(rq.pop_front()));
            end
            if (m_head) begin
                nheads++;
                check("rd_to_head", 32'(cyc - last_rd), 32'(exp_rd_head));
                if (last_head >= 0) check("head_gap", 32'(cyc - last_head), 32'(exp_head_gap));
                last_head = cyc;
            end
            if (m_wr_en) begin
                nwr++;
                if (wq_addr.size() == 0) begin
                    check("wr_unexpected", 32'(m_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 32'(m_wr_addr), 32'(wq_addr.pop_front()));
                    check("wr_data", m_wr_data, wq_data.pop_front());
                end
            end
            if (m_ldone) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_exp(input int n_rd, input int base, input int n_wr);
        nheads = 0; nwr = 0; last_head = -1;
        for (int i = 0; i < n_rd; i++) rq.push_back(10'(i));
        for (int k = 0; k < n_wr; k++) begin
            wq_addr.push_back(10'(base + k));
            wq_data.push_back(node_val(4'(k)));
        end
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        if (act) start_b = 1'b1; else start_a = 1'b1;
        s = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_ldone(input string tag, input int bound, input int prev);
        bit seen = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            #2;
            if (ndone > prev) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    int s, nd0;
    bit found;

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        exp_rd_head = 2; exp_head_gap = 5;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_ldone",   32'(ldone_a),   32'd0);
        check("rst_err",     32'(err_a),     32'd0);
        check("rst_rd_en",   32'(rd_en_a),   32'd0);
        check("rst_rd_addr", 32'(rd_addr_a), 32'd0);
        check("rst_head",    32'(head_a),    32'd0);
        check("rst_sel",     32'(sel_a),     32'hF);
        check("rst_wr_en",   32'(wr_en_a),   32'd0);
        check("rst_wr_addr_b", 32'(wr_addr_b), 32'd0);
        check("rst_wr_data", wr_data_a,      32'd0);
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);

        // basic pass, done two cycles after each head
        act = 1'b0; dmode = 0;
        nd0 = ndone; push_exp(3, 0, 10);
        pulse_start(s);
        #1 check("t1_busy", 32'(m_busy), 32'd1);
        wait_ldone("t1_ldone_timeout", 200, nd0);
        check("t1_latency", 32'(done_cyc - s), 32'd27);
        check("t1_heads", 32'(nheads), 32'd3);
        check("t1_writes", 32'(nwr), 32'd10);
        check("t1_rdq_left", 32'(rq.size()), 32'd0);
        check("t1_err", 32'(m_err), 32'd0);
        @(negedge clk); #1;
        check("t1_busy_after", 32'(m_busy), 32'd0);
        check("t1_ldone_pulse", 32'(m_ldone), 32'd0);

        // done held high: first WAIT_NODE cycle masked
        dmode = 1;
        nd0 = ndone; push_exp(3, 0, 10);
        pulse_start(s);
        wait_ldone("t2_ldone_timeout", 200, nd0);
        check("t2_latency", 32'(done_cyc - s), 32'd27);
        check("t2_heads", 32'(nheads), 32'd3);
        check("t2_writes", 32'(nwr), 32'd10);
        repeat (2) @(negedge clk);

        // done never rises: timeout, no writes
        dmode = 2;
        nd0 = ndone; push_exp(1, 0, 0);
        pulse_start(s);
        wait_ldone("t3_ldone_timeout", 200, nd0);
        check("t3_err", 32'(m_err), 32'd1);
        check("t3_heads", 32'(nheads), 32'd1);
        @(negedge clk); #1;
        check("t3_err_sticky", 32'(m_err), 32'd1);
        check("t3_writes", 32'(nwr), 32'd0);
        check("t3_rdq_left", 32'(rq.size()), 32'd0);

        // next start clears the error
        dmode = 0;
        nd0 = ndone; push_exp(3, 0, 10);
        pulse_start(s);
        #1 check("t4_err_cleared", 32'(m_err), 32'd0);
        wait_ldone("t4_ldone_timeout", 200, nd0);
        check("t4_writes", 32'(nwr), 32'd10);
        repeat (2) @(negedge clk);

        // reset during drain at k=4
        nd0 = ndone; push_exp(3, 0, 4);
        pulse_start(s);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_sel == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach_k4", 32'(found), 32'd1);
        #1 rst_n_a = 1'b0;
        #1;
        check("t5_rst_busy",  32'(m_busy),  32'd0);
        check("t5_rst_sel",   32'(m_sel),   32'hF);
        check("t5_rst_wr_en", 32'(m_wr_en), 32'd0);
        check("t5_rst_rd_en", 32'(m_rd_en), 32'd0);
        check("t5_rst_head",  32'(m_head),  32'd0);
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_ldone", 32'(ndone), 32'(nd0));
        check("t5_writes", 32'(nwr), 32'd4);
        check("t5_wq_left", 32'(wq_addr.size()), 32'd0);

        // instance B: longer memory latency, wrapping write address, start while busy
        act = 1'b1; dmode = 0;
        exp_rd_head = 4; exp_head_gap = 7;
        nd0 = ndone; push_exp(3, 1020, 10);
        pulse_start(s);
        repeat (4) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_ldone("t6_ldone_timeout", 300, nd0);
        check("t6_latency", 32'(done_cyc - s), 32'd33);
        check("t6_heads", 32'(nheads), 32'd3);
        check("t6_writes", 32'(nwr), 32'd10);
        repeat (15) @(negedge clk);
        check("t6_single_pass", 32'(ndone - nd0), 32'd1);
        check("t6_rdq_left", 32'(rq.size()), 32'd0);
        check("t6_wq_left", 32'(wq_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
